rcc_sysclk_sw_ctrl: RTL and testbench

RCC_SYSCLK_SW_CTRL -- requirements
Module: rcc_sysclk_sw_ctrl

---
 rtl/rcc_pkg.sv | 21 ++
 rtl/rcc_sw_cnt.sv | 25 ++
 rtl/rcc_sysclk_sw_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rcc_sysclk_sw_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rcc_pkg.sv
// rtl/rcc_pkg.sv - shared source codes, FSM states and one-hot helper for the sysclk switch
package rcc_pkg;

  localparam logic [1:0] SRC_HSI  = 2'd0;
  localparam logic [1:0] SRC_CSI  = 2'd1;
  localparam logic [1:0] SRC_HSE  = 2'd2;
  localparam logic [1:0] SRC_PLL1 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_GATE_OFF = 3'd2,
    ST_SWITCH   = 3'd3,
    ST_GATE_ON  = 3'd4
  } rcc_state_t;

  function automatic logic [3:0] onehot(input logic [1:0] src);
    onehot = 4'b0001 << src;
  endfunction

endpackage

// File: rtl/rcc_sw_cnt.sv
// rtl/rcc_sw_cnt.sv - loadable down-counter with zero flag, shared by timeout and gate timing
module rcc_sw_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/rcc_sysclk_sw_ctrl.sv
// rtl/rcc_sysclk_sw_ctrl.sv - glitch-free sysclk source switch sequencer with ready timeout and CSS fallback
module rcc_sysclk_sw_ctrl
  import rcc_pkg::*;
#(
  parameter int GATE_CYC = 4,
  parameter int RDY_TMO  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_req,
  input  logic [1:0] sw_sel,
  input  logic [3:0] src_rdy,
  input  logic       css_fail,
  output logic [3:0] clk_en,
  output logic [1:0] mux_sel,
  output logic [1:0] sws,
  output logic       busy,
  output logic       sw_done,
  output logic       sw_err,
  output logic       css_sw
);

  // Counter runs down to zero, so phases of N cycles load N-1.
  localparam logic [7:0] GATE_LD = 8'(GATE_CYC - 1);
  localparam logic [7:0] TMO_LD  = 8'(RDY_TMO - 1);

  rcc_state_t r_state, w_nxt_state;
  logic [1:0] r_target, w_nxt_target;
  logic [1:0] r_sws, w_nxt_sws;
  logic [1:0] r_mux_sel, w_nxt_mux_sel;
  logic       r_css_sw, w_nxt_css_sw;
  logic       r_sw_done, w_nxt_sw_done;
  logic       r_sw_err, w_nxt_sw_err;
  logic       w_cnt_load, w_cnt_dec, w_cnt_zero, w_css_hit;
  logic [7:0] w_cnt_val;

  rcc_sw_cnt u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_target  <= SRC_HSI;
      r_sws     <= SRC_HSI;
      r_mux_sel <= SRC_HSI;
      r_css_sw  <= 1'b0;
      r_sw_done <= 1'b0;
      r_sw_err  <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_target  <= w_nxt_target;
      r_sws     <= w_nxt_sws;
      r_mux_sel <= w_nxt_mux_sel;
      r_css_sw  <= w_nxt_css_sw;
      r_sw_done <= w_nxt_sw_done;
      r_sw_err  <= w_nxt_sw_err;
    end
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_target  = r_target;
    w_nxt_sws     = r_sws;
    w_nxt_mux_sel = r_mux_sel;
    w_nxt_css_sw  = r_css_sw;
    w_nxt_sw_done = 1'b0;
    w_nxt_sw_err  = 1'b0;
    w_cnt_load    = 1'b0;
    w_cnt_val     = GATE_LD;
    w_cnt_dec     = 1'b0;
    w_css_hit     = css_fail && (r_target == SRC_HSE);

    case (r_state)
      ST_IDLE: begin
        // CSS fallback outranks a same-cycle software request.
        if (css_fail && (r_sws == SRC_HSE)) begin
          w_nxt_target = SRC_HSI;
          w_nxt_css_sw = 1'b1;
          w_nxt_state  = ST_GATE_OFF;
          w_cnt_load   = 1'b1;
        end else if (sw_req && (sw_sel != r_sws)) begin
          w_nxt_target = sw_sel;
          w_nxt_css_sw = 1'b0;
          w_nxt_state  = ST_WAIT_RDY;
          w_cnt_load   = 1'b1;
          w_cnt_val    = TMO_LD;
        end
      end
      ST_WAIT_RDY: begin
        if (w_css_hit) begin
          w_nxt_state = ST_IDLE;
        end else if (src_rdy[r_target]) begin
          w_nxt_state = ST_GATE_OFF;
          w_cnt_load  = 1'b1;
        end else if (w_cnt_zero) begin
          w_nxt_state  = ST_IDLE;
          w_nxt_sw_err = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_GATE_OFF: begin
        if (w_cnt_zero) begin
          w_nxt_state   = ST_SWITCH;
          w_nxt_mux_sel = r_target;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_SWITCH: begin
        w_nxt_state = ST_GATE_ON;
        w_cnt_load  = 1'b1;
      end
      ST_GATE_ON: begin
        if (w_cnt_zero) begin
          w_nxt_state   = ST_IDLE;
          w_nxt_sws     = r_target;
          w_nxt_sw_done = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase

    // HSE lost mid-sequence: restart the gate-off phase towards HSI.
    if (w_css_hit && ((r_state == ST_GATE_OFF) || (r_state == ST_SWITCH) ||
                      (r_state == ST_GATE_ON))) begin
      w_nxt_target  = SRC_HSI;
      w_nxt_css_sw  = 1'b1;
      w_nxt_state   = ST_GATE_OFF;
      w_nxt_mux_sel = r_mux_sel;
      w_nxt_sws     = r_sws;
      w_nxt_sw_done = 1'b0;
      w_cnt_load    = 1'b1;
      w_cnt_val     = GATE_LD;
      w_cnt_dec     = 1'b0;
    end
  end

  always_comb begin
    case (r_state)
      ST_GATE_OFF, ST_SWITCH: clk_en = 4'b0000;
      ST_GATE_ON:             clk_en = onehot(r_target);
      default:                clk_en = onehot(r_sws);
    endcase
  end

  assign mux_sel = r_mux_sel;
  assign sws     = r_sws;
  assign busy    = (r_state != ST_IDLE);
  assign sw_done = r_sw_done;
  assign sw_err  = r_sw_err;
  assign css_sw  = r_css_sw;

endmodule

// File: tb/tb_rcc_sysclk_sw_ctrl.sv
// tb/tb_rcc_sysclk_sw_ctrl.sv - directed and randomized bench for the sysclk switch sequencer
module tb_rcc_sysclk_sw_ctrl;

  localparam int G = 4;
  localparam int T = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_req = 1'b0;
  logic [1:0] sw_sel = 2'd0;
  logic [3:0] src_rdy = 4'd0;
  logic       css_fail = 1'b0;
  logic [3:0] clk_en;
  logic [1:0] mux_sel;
  logic [1:0] sws;
  logic       busy, sw_done, sw_err, css_sw;

  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;
  logic [1:0] prev_mux = 2'd0;
  logic [3:0] prev_en = 4'd1;
  logic [1:0] m_sws;
  logic       m_css;

  rcc_sysclk_sw_ctrl #(.GATE_CYC(G), .RDY_TMO(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_req   (sw_req),
    .sw_sel   (sw_sel),
    .src_rdy  (src_rdy),
    .css_fail (css_fail),
    .clk_en   (clk_en),
    .mux_sel  (mux_sel),
    .sws      (sws),
    .busy     (busy),
    .sw_done  (sw_done),
    .sw_err   (sw_err),
    .css_sw   (css_sw)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_onehot(input logic [1:0] s);
    logic [3:0] v;
    v = 4'd0;
    v[s] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Gate invariants watched on every cycle outside reset windows.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      checks++;
      assert ($countones(clk_en) <= 1) else begin
        errors++;
        $error("FAIL multi_hot observed=%0h expected=onehot", clk_en);
      end
      if (mux_sel !== prev_mux) begin
        checks++;
        assert ((prev_en == 4'd0) && (clk_en == 4'd0)) else begin
          errors++;
          $error("FAIL mux_gate observed=%0h/%0h expected=0/0", prev_en, clk_en);
        end
      end
    end
    prev_mux <= mux_sel;
    prev_en  <= clk_en;
  end

  task automatic wait_pulse(input int limit, output int n, output int zeros,
                            output logic done, output logic err);
    n = 0; zeros = 0; done = 1'b0; err = 1'b0;
    while ((n < limit) && !done && !err) begin
      @(negedge clk);
      sw_req = 1'b0;
      n++;
      if (clk_en == 4'd0) zeros++;
      done = sw_done;
      err  = sw_err;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sws"}, 32'(sws), 32'(m_sws));
    chk({tag, "_mux"}, 32'(mux_sel), 32'(m_sws));
    chk({tag, "_en"}, 32'(clk_en), 32'(ref_onehot(m_sws)));
    chk({tag, "_css"}, 32'(css_sw), 32'(m_css));
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic run_req(input logic [1:0] sel, input logic rdy_ok);
    logic [3:0] r;
    int n, z;
    logic d, e;
    r = 4'($urandom);
    r[sel] = rdy_ok;
    src_rdy = r;
    sw_sel = sel;
    sw_req = 1'b1;
    if (sel == m_sws) begin
      @(negedge clk);
      sw_req = 1'b0;
      chk("ign_busy", 32'(busy), 0);
      chk("ign_pulse", 32'({sw_done, sw_err}), 0);
    end else begin
      wait_pulse(T + 10, n, z, d, e);
      m_css = 1'b0;
      if (rdy_ok) begin
        chk("done_lat", n, 2 * G + 3);
        chk("done_seen", 32'(d), 1);
        chk("gate_zero_cycles", z, G + 1);
        m_sws = sel;
      end else begin
        chk("err_lat", n, T + 1);
        chk("err_seen", 32'(e), 1);
        chk("err_no_gate", z, 0);
      end
      chk_idle_outputs("req");
      @(negedge clk);
      chk("pulse_width", 32'({sw_done, sw_err}), 0);
    end
  endtask

  initial begin
    int n, z;
    logic d, e;

    m_sws = 2'd0;
    m_css = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_pulses", 32'({sw_done, sw_err}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // PLL1 from reset, target already ready.
    src_rdy = 4'b1001; sw_sel = 2'd3; sw_req = 1'b1;
    wait_pulse(100, n, z, d, e);
    chk("pll_lat", n, 11);
    chk("pll_done", 32'(d), 1);
    m_sws = 2'd3;
    chk_idle_outputs("pll");
    chk("pll_en", 32'(clk_en), 32'(4'b1000));

    // Reset in the middle of GATE_OFF.
    src_rdy = 4'b0010; sw_sel = 2'd1; sw_req = 1'b1;
    @(negedge clk); sw_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_gate_off", 32'(clk_en), 0);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_sws = 2'd0; m_css = 1'b0;
    chk_idle_outputs("async_rst");
    chk("async_rst_pulses", 32'({sw_done, sw_err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_en", 32'(clk_en), 32'(4'b0001));
    end

    // Same-source request ignored, then a request while busy is dropped.
    run_req(2'd0, 1'b1);
    src_rdy = 4'b1111; sw_sel = 2'd1; sw_req = 1'b1;
    @(negedge clk);
    chk("busy_first", 32'(busy), 1);
    sw_sel = 2'd3; sw_req = 1'b1;
    wait_pulse(100, n, z, d, e);
    chk("busy_req_lat", n, 2 * G + 2);
    m_sws = 2'd1;
    chk_idle_outputs("busy_req");

    // Ready timeout on HSE.
    run_req(2'd0, 1'b1);
    run_req(2'd2, 1'b0);

    // CSS failure while running on HSE.
    run_req(2'd2, 1'b1);
    css_fail = 1'b1;
    wait_pulse(100, n, z, d, e);
    chk("css_lat", n, 2 * G + 2);
    chk("css_zero_cycles", z, G + 1);
    chk("css_done", 32'(d), 1);
    m_sws = 2'd0; m_css = 1'b1;
    chk_idle_outputs("css");
    repeat (3) begin
      @(negedge clk);
      chk("css_hold_idle", 32'(busy), 0);
    end
    css_fail = 1'b0;
    run_req(2'd1, 1'b1);

    // CSS and sw_req together while on HSE: CSS wins.
    run_req(2'd2, 1'b1);
    css_fail = 1'b1; src_rdy = 4'b1111; sw_sel = 2'd3; sw_req = 1'b1;
    wait_pulse(100, n, z, d, e);
    chk("css_win_lat", n, 2 * G + 2);
    m_sws = 2'd0; m_css = 1'b1;
    chk_idle_outputs("css_win");
    css_fail = 1'b0;

    // CSS during GATE_OFF towards HSE retargets to HSI.
    src_rdy = 4'b0100; sw_sel = 2'd2; sw_req = 1'b1;
    @(negedge clk); sw_req = 1'b0;
    chk("css_clr_on_accept", 32'(css_sw), 0);
    @(negedge clk);
    css_fail = 1'b1;
    wait_pulse(100, n, z, d, e);
    chk("retarget_lat", n, 2 * G + 2);
    chk("retarget_zero_cycles", z, G + 1);
    m_sws = 2'd0; m_css = 1'b1;
    chk_idle_outputs("retarget");
    css_fail = 1'b0;

    // CSS while waiting for HSE ready aborts without error.
    src_rdy = 4'b0000; sw_sel = 2'd2; sw_req = 1'b1;
    @(negedge clk); sw_req = 1'b0;
    repeat (2) @(negedge clk);
    css_fail = 1'b1;
    @(negedge clk);
    chk("abort_err", 32'(sw_err), 0);
    m_css = 1'b0;
    chk_idle_outputs("abort");

    // CSS with no HSE involvement does nothing.
    repeat (4) begin
      @(negedge clk);
      chk("css_noop_busy", 32'(busy), 0);
    end
    css_fail = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_req(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
